sprite_draw: RTL and testbench
==============================

// Module: sprite_draw
// PURPOSE
//  Framebuffer writer for the Chip-8 video path. Executes DXYN draw and 00E0 clear commands from the CPU.
//  Draws XOR 8-pixel-wide sprite rows into the 16-bit-word framebuffer and reports collision.
//  Owns the write port of the dual-port framebuffer RAM. The VGA scan-out owns the read port, so no arbitration is needed.
// PARAMETERS
//  FB_AW     9    framebuffer word address width (512 words = 128x64 bits)
//  SPR_AW    4    sprite row address width (max 16 rows)
// PORTS
//  clk        in   1   system clock
//  reset      in   1   synchronous, active-high reset
//  hires      in   1   1: 128x64 screen, row stride 8 words; 0: 64x32, stride 4 words, words 0..127
//  start      in   1   draw request, sampled only in IDLE
//  clear      in   1   clear-screen request, sampled only in IDLE
//  x          in   7   sprite X (taken mod screen width)
//  y          in   6   sprite Y (taken mod screen height)
//  n          in   4   row count; 0 means 16 rows
//  busy       out  1   high from the cycle after an accepted request until done
//  done       out  1   one-cycle pulse when the command completes
//  collision  out  1   VF result: 1 if any set pixel was erased; held until next start/clear
//  sprAddr    out  4   sprite row index (relative to I), sprite RAM read, 1-cycle latency
//  sprData    in   8   sprite row byte, bit7 = leftmost pixel
//  fbAddr     out  9   framebuffer word address, 1-cycle read latency
//  fbRdData   in   16  framebuffer read data, bit15 = leftmost pixel of word
//  fbWrData   out  16  framebuffer write data
//  fbWe       out  1   framebuffer write enable
// BEHAVIOUR
//  Reset values: busy=0, done=0, collision=0, fbWe=0, fbAddr=0, fbWrData=0, sprAddr=0, state=IDLE.
//  Reset is honoured mid-command and drops fbWe in the same cycle. A partially drawn sprite stays in RAM.
//  States: IDLE, FETCH, RD0, WR0, RD1, WR1, CLEAR, DONE.
//  IDLE: clear has priority over start when both are high. start/clear while busy is ignored.
//    Both requests latch hires, x, y and n, and clear collision.
//  FETCH: drive sprAddr=row. Next state RD0.
//  RD0: sprData valid. Form win[23:0] = {sprData,16'h0} >> x[3:0].
//    Drive fbAddr = (y+row)*stride + x[6:4].
//  WR0: fbWrData = fbRdData ^ win[23:8]; fbWe=1. Set collision if |(fbRdData & win[23:8]).
//    Next state is RD1 if win[7:0]!=0, otherwise the next row.
//  RD1 and WR1: same operation on word index+1 with mask {win[7:0],8'h0}.
//  Next row: row++. Go to DONE when row==rows or y+row reaches screen height (clip). Otherwise go to FETCH.
//  Right-edge clip: when x[6:4]==stride-1, skip RD1/WR1.
//  Cycle counts: 3 cycles per unsplit row, 5 per split row. done pulses in DONE, one cycle after the last write.
//    busy drops in that same cycle.
//  CLEAR: writes 0 to words 0..(hires?511:127), one per cycle, then DONE.
//  Address arithmetic is done at 9 bits. Row index wraps at 16. No carry escapes FB_AW.
// CONFIGURATION
//  SPRITE_WRAP_EN defined:
//    Rows past the bottom edge wrap to y=0, and the right-edge word wraps to word 0 of the same row. No clipping.
//  SPRITE_WRAP_EN undefined: clip as above (default, SCHIP behaviour).
// STRUCTURE
//  Package chip8_video_pkg holds:
//    FB_WORDS_HI=512, FB_WORDS_LO=128, STRIDE_HI=8, STRIDE_LO=4, SCR_W/H for both modes, and the state enum.
//  Sub-module sprite_row_shifter: combinational. Takes byte and x[3:0], produces the two 16-bit masks and a split flag.
//  The FSM and counters stay in sprite_draw.
// TESTING
//  1. Blank fb, lores, x=0,y=0,n=1,sprData=8'hF0, start at T:
//     fbWe at T+3 only, addr 0, data 16'hF000. done at T+4, collision=0.
//  2. Repeat test 1 on the result:
//     word 0 returns to 16'h0000, collision=1, held until the next start.
//  3. Hires, x=13,y=2,n=1,sprData=8'hFF:
//     writes 16'h0007 to addr 16, then 16'hF800 to addr 17. done at T+6.
//  4. Lores, x=60,y=30,n=3,sprData=8'hFF:
//     clip build: only rows 30 and 31 drawn, one word each (addr 123 and 127), 16'h000F.
//     SPRITE_WRAP_EN build: row 0 is also drawn, and the second word of each row goes to the row's first word.
//  5. clear and start together, hires:
//     exactly 512 zero writes at addresses 0..511 in order, then done. start is ignored throughout.
//  6. reset asserted during WR1:
//     fbWe=0 the next cycle, busy=0 and collision=0. A later start behaves as in test 1.

Source files
------------

// File: rtl/chip8_video_pkg.sv
// Geometry constants, draw FSM state encoding and address helper shared by the Chip-8 video path.
package chip8_video_pkg;

    localparam int unsigned FB_AW       = 9;
    localparam int unsigned SPR_AW      = 4;
    localparam int unsigned FB_WORDS_HI = 512;
    localparam int unsigned FB_WORDS_LO = 128;
    localparam int unsigned STRIDE_HI   = 8;
    localparam int unsigned STRIDE_LO   = 4;
    localparam int unsigned SCR_W_HI    = 128;
    localparam int unsigned SCR_H_HI    = 64;
    localparam int unsigned SCR_W_LO    = 64;
    localparam int unsigned SCR_H_LO    = 32;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_RD0,
        ST_WR0,
        ST_RD1,
        ST_WR1,
        ST_CLEAR,
        ST_DONE
    } draw_state_e;

    // Word address of the first word of screen row ypos.
    function automatic logic [FB_AW-1:0] fb_row_base(input logic hi, input logic [FB_AW-1:0] ypos);
        return hi ? FB_AW'(ypos << $clog2(STRIDE_HI)) : FB_AW'(ypos << $clog2(STRIDE_LO));
    endfunction

endpackage

// File: rtl/sprite_row_shifter.sv
// Places an 8-pixel sprite byte at a pixel offset within a 16-bit word pair.
// mask0_c covers the addressed word, mask1_c the following word; split_c flags a non-empty mask1_c.
module sprite_row_shifter
    import chip8_video_pkg::*;
(
    input  logic [7:0]  spr_byte,
    input  logic [3:0]  shift,
    output logic [15:0] mask0_c,
    output logic [15:0] mask1_c,
    output logic        split_c
);

    logic [23:0] win;

    always_comb begin
        win     = {spr_byte, 16'h0000} >> shift;
        mask0_c = win[23:8];
        mask1_c = {win[7:0], 8'h00};
        split_c = |win[7:0];
    end

endmodule

// File: rtl/sprite_draw.sv
// Chip-8 DXYN / 00E0 framebuffer writer: XORs sprite rows into the word framebuffer and reports collision.
// Define SPRITE_WRAP_EN to wrap sprites at the bottom and right screen edges instead of clipping.
module sprite_draw
    import chip8_video_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              hires,
    input  logic              start,
    input  logic              clear,
    input  logic [6:0]        x,
    input  logic [5:0]        y,
    input  logic [3:0]        n,
    output logic              busy,
    output logic              done,
    output logic              collision,
    output logic [SPR_AW-1:0] sprAddr,
    input  logic [7:0]        sprData,
    output logic [FB_AW-1:0]  fbAddr,
    input  logic [15:0]       fbRdData,
    output logic [15:0]       fbWrData,
    output logic              fbWe
);

    draw_state_e       state_q, state_d;
    logic              hires_q, hires_d;
    logic [6:0]        x_q, x_d;
    logic [5:0]        y_q, y_d;
    logic [4:0]        rows_q, rows_d;
    logic [SPR_AW-1:0] row_q, row_d;
    logic [15:0]       mask0_q, mask0_d;
    logic [15:0]       mask1_q, mask1_d;
    logic              split_q, split_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              coll_q, coll_d;
    logic              fb_we_q, fb_we_d;
    logic [SPR_AW-1:0] spr_addr_q, spr_addr_d;
    logic [FB_AW-1:0]  fb_addr_q, fb_addr_d;

    logic [15:0]       shf_mask0;
    logic [15:0]       shf_mask1;
    logic              shf_split;

    logic [2:0]        stride_last;
    logic [2:0]        word_idx;
    logic [2:0]        word_idx2;
    logic [FB_AW-1:0]  scr_h;
    logic [FB_AW-1:0]  clear_last;
    logic [FB_AW-1:0]  ypos;
    logic [FB_AW-1:0]  row_base;
    logic [4:0]        row_cnt_next;
    logic              last_row;
    logic              take_rd1;
`ifndef SPRITE_WRAP_EN
    logic [FB_AW-1:0]  ypos_next;
`endif

    sprite_row_shifter u_shifter (
        .spr_byte (sprData),
        .shift    (x_q[3:0]),
        .mask0_c  (shf_mask0),
        .mask1_c  (shf_mask1),
        .split_c  (shf_split)
    );

    // Screen geometry of the latched command and the edge handling for the current row.
    always_comb begin
        stride_last  = hires_q ? 3'(STRIDE_HI - 1) : 3'(STRIDE_LO - 1);
        scr_h        = hires_q ? FB_AW'(SCR_H_HI) : FB_AW'(SCR_H_LO);
        clear_last   = hires_q ? FB_AW'(FB_WORDS_HI - 1) : FB_AW'(FB_WORDS_LO - 1);
        word_idx     = x_q[6:4];
        row_cnt_next = 5'(row_q) + 5'd1;
`ifdef SPRITE_WRAP_EN
        ypos         = (FB_AW'(y_q) + FB_AW'(row_q)) & (scr_h - FB_AW'(1));
        word_idx2    = (word_idx + 3'd1) & stride_last;
        take_rd1     = split_q;
        last_row     = (row_cnt_next == rows_q);
`else
        ypos         = FB_AW'(y_q) + FB_AW'(row_q);
        ypos_next    = FB_AW'(y_q) + FB_AW'(row_cnt_next);
        word_idx2    = word_idx + 3'd1;
        take_rd1     = split_q && (word_idx != stride_last);
        last_row     = (row_cnt_next == rows_q) || (ypos_next >= scr_h);
`endif
        row_base     = fb_row_base(hires_q, ypos);
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d    = state_q;
        hires_d    = hires_q;
        x_d        = x_q;
        y_d        = y_q;
        rows_d     = rows_q;
        row_d      = row_q;
        mask0_d    = mask0_q;
        mask1_d    = mask1_q;
        split_d    = split_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        coll_d     = coll_q;
        fb_we_d    = 1'b0;
        spr_addr_d = spr_addr_q;
        fb_addr_d  = fb_addr_q;

        case (state_q)
            ST_IDLE: begin
                if (clear || start) begin
                    hires_d = hires;
                    x_d     = hires ? (x & 7'(SCR_W_HI - 1)) : (x & 7'(SCR_W_LO - 1));
                    y_d     = hires ? (y & 6'(SCR_H_HI - 1)) : (y & 6'(SCR_H_LO - 1));
                    rows_d  = (n == 4'd0) ? 5'd16 : 5'(n);
                    coll_d  = 1'b0;
                    busy_d  = 1'b1;
                end
                if (clear) begin
                    fb_addr_d = '0;
                    fb_we_d   = 1'b1;
                    state_d   = ST_CLEAR;
                end else if (start) begin
                    row_d      = '0;
                    spr_addr_d = '0;
                    state_d    = ST_FETCH;
                end
            end
            ST_FETCH: begin
                fb_addr_d = row_base + FB_AW'(word_idx);
                state_d   = ST_RD0;
            end
            ST_RD0: begin
                mask0_d = shf_mask0;
                mask1_d = shf_mask1;
                split_d = shf_split;
                fb_we_d = 1'b1;
                state_d = ST_WR0;
            end
            ST_WR0, ST_WR1: begin
                if (state_q == ST_WR0) begin
                    coll_d = coll_q | (|(fbRdData & mask0_q));
                end else begin
                    coll_d = coll_q | (|(fbRdData & mask1_q));
                end
                if ((state_q == ST_WR0) && take_rd1) begin
                    fb_addr_d = row_base + FB_AW'(word_idx2);
                    state_d   = ST_RD1;
                end else if (last_row) begin
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    row_d      = row_q + SPR_AW'(1);
                    spr_addr_d = row_q + SPR_AW'(1);
                    state_d    = ST_FETCH;
                end
            end
            ST_RD1: begin
                fb_we_d = 1'b1;
                state_d = ST_WR1;
            end
            ST_CLEAR: begin
                if (fb_addr_q == clear_last) begin
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    fb_addr_d = fb_addr_q + FB_AW'(1);
                    fb_we_d   = 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            hires_q    <= 1'b0;
            x_q        <= '0;
            y_q        <= '0;
            rows_q     <= '0;
            row_q      <= '0;
            mask0_q    <= '0;
            mask1_q    <= '0;
            split_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            coll_q     <= 1'b0;
            fb_we_q    <= 1'b0;
            spr_addr_q <= '0;
            fb_addr_q  <= '0;
        end else begin
            state_q    <= state_d;
            hires_q    <= hires_d;
            x_q        <= x_d;
            y_q        <= y_d;
            rows_q     <= rows_d;
            row_q      <= row_d;
            mask0_q    <= mask0_d;
            mask1_q    <= mask1_d;
            split_q    <= split_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            coll_q     <= coll_d;
            fb_we_q    <= fb_we_d;
            spr_addr_q <= spr_addr_d;
            fb_addr_q  <= fb_addr_d;
        end
    end

    // Write data needs the RAM word returned this cycle, so it is formed combinationally.
    always_comb begin
        fbWrData = 16'h0000;
        if (state_q == ST_WR0) begin
            fbWrData = fbRdData ^ mask0_q;
        end else if (state_q == ST_WR1) begin
            fbWrData = fbRdData ^ mask1_q;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign collision = coll_q;
    assign sprAddr   = spr_addr_q;
    assign fbAddr    = fb_addr_q;
    assign fbWe      = fb_we_q;

endmodule

// File: tb/tb_sprite_draw.sv
// Self-checking bench for sprite_draw: directed scenarios plus random draws against a pixel-level model.
module tb_sprite_draw;

    logic        clk = 1'b0;
    logic        reset;
    logic        hires;
    logic        start;
    logic        clear;
    logic [6:0]  x;
    logic [5:0]  y;
    logic [3:0]  n;
    logic        busy;
    logic        done;
    logic        collision;
    logic [3:0]  sprAddr;
    logic [7:0]  sprData;
    logic [8:0]  fbAddr;
    logic [15:0] fbRdData;
    logic [15:0] fbWrData;
    logic        fbWe;

    logic [15:0] fb_mem  [512];
    logic [7:0]  spr_mem [16];
    logic [15:0] ref_fb  [512];

    int          n_checks = 0;
    int          n_pass   = 0;
    int          busy_bad;
    int          wr_cyc  [$];
    logic [8:0]  wr_addr [$];
    logic [15:0] wr_data [$];

    sprite_draw dut (
        .clk       (clk),
        .reset     (reset),
        .hires     (hires),
        .start     (start),
        .clear     (clear),
        .x         (x),
        .y         (y),
        .n         (n),
        .busy      (busy),
        .done      (done),
        .collision (collision),
        .sprAddr   (sprAddr),
        .sprData   (sprData),
        .fbAddr    (fbAddr),
        .fbRdData  (fbRdData),
        .fbWrData  (fbWrData),
        .fbWe      (fbWe)
    );

    always #5 clk = ~clk;

    // Framebuffer and sprite RAMs, both with one cycle of read latency.
    always @(posedge clk) begin
        if (fbWe) fb_mem[fbAddr] <= fbWrData;
        fbRdData <= fb_mem[fbAddr];
        sprData  <= spr_mem[sprAddr];
    end

    function automatic int fb_diff();
        int d = 0;
        for (int i = 0; i < 512; i++) if (fb_mem[i] !== ref_fb[i]) d++;
        return d;
    endfunction

    // Pixel-level reference: XOR each set sprite pixel onto the screen, clipping or wrapping at edges.
    task automatic model_draw(input bit hi, input int xi, input int yi, input int ni,
                              output bit coll, output int lat, output int nwr);
        int w      = hi ? 128 : 64;
        int h      = hi ? 64 : 32;
        int stride = hi ? 8 : 4;
        int rows   = (ni == 0) ? 16 : ni;
        coll = 1'b0; lat = 1; nwr = 0;
        xi = xi % w; yi = yi % h;
        for (int r = 0; r < rows; r++) begin
            int py = yi + r;
            bit second = 1'b0;
`ifdef SPRITE_WRAP_EN
            py = py % h;
`else
            if (py >= h) break;
`endif
            for (int b = 0; b < 8; b++) begin
                int px = xi + b;
                int idx;
                int bp;
                if (spr_mem[r][7-b] == 1'b1) begin
`ifdef SPRITE_WRAP_EN
                    px = px % w;
`else
                    if (px >= w) continue;
`endif
                    if ((xi % 16) + b >= 16) second = 1'b1;
                    idx = py * stride + px / 16;
                    bp  = 15 - (px % 16);
                    if (ref_fb[idx][bp] == 1'b1) coll = 1'b1;
                    ref_fb[idx][bp] = ~ref_fb[idx][bp];
                end
            end
            lat += second ? 5 : 3;
            nwr += second ? 2 : 1;
        end
    endtask

    // Issue one command and log every write until done or the cycle budget runs out.
    task automatic run_cmd(input logic c_clr, input logic c_start, input logic c_hi,
                           input logic [6:0] c_x, input logic [5:0] c_y, input logic [3:0] c_n,
                           input bit hold, output int lat, output bit tmo);
        wr_cyc.delete(); wr_addr.delete(); wr_data.delete();
        busy_bad = 0; lat = 0; tmo = 1'b1;
        @(negedge clk);
        clear = c_clr; start = c_start; hires = c_hi; x = c_x; y = c_y; n = c_n;
        @(negedge clk);
        clear = 1'b0; start = hold;
        hires = 1'($urandom); x = 7'($urandom); y = 6'($urandom); n = 4'($urandom);
        for (int k = 1; k <= 1000; k++) begin
            if (fbWe) begin
                wr_cyc.push_back(k); wr_addr.push_back(fbAddr); wr_data.push_back(fbWrData);
            end
            if (done) begin
                lat = k; tmo = 1'b0;
                break;
            end
            if (busy !== 1'b1) busy_bad++;
            @(negedge clk);
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; clear = 1'b0; hires = 1'b0; x = '0; y = '0; n = '0;
        for (int i = 0; i < 16; i++) spr_mem[i] = 8'h00;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        n_checks++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", busy); else n_pass++;
        n_checks++; if (done !== 1'b0) $display("FAIL rst_done: got %b want 0", done); else n_pass++;
        n_checks++; if (collision !== 1'b0) $display("FAIL rst_coll: got %b want 0", collision); else n_pass++;
        n_checks++; if (fbWe !== 1'b0) $display("FAIL rst_we: got %b want 0", fbWe); else n_pass++;
        n_checks++; if (fbAddr !== 9'd0) $display("FAIL rst_addr: got %0d want 0", fbAddr); else n_pass++;
        n_checks++; if (fbWrData !== 16'h0) $display("FAIL rst_wdata: got %h want 0000", fbWrData); else n_pass++;
        n_checks++; if (sprAddr !== 4'd0) $display("FAIL rst_spraddr: got %0d want 0", sprAddr); else n_pass++;
    endtask

    task automatic test_clear_start();
        int lat; bit tmo; int bad;
        run_cmd(1'b1, 1'b1, 1'b1, 7'd5, 6'd3, 4'd2, 1'b1, lat, tmo);
        for (int i = 0; i < 512; i++) ref_fb[i] = 16'h0;
        n_checks++; if (tmo) $display("FAIL clr_timeout: got no done want done"); else n_pass++;
        n_checks++; if (lat != 513) $display("FAIL clr_latency: got %0d want 513", lat); else n_pass++;
        n_checks++; if (wr_addr.size() != 512) $display("FAIL clr_writes: got %0d want 512", wr_addr.size()); else n_pass++;
        bad = 0;
        for (int i = 0; i < wr_addr.size(); i++)
            if (wr_addr[i] !== 9'(i) || wr_data[i] !== 16'h0 || wr_cyc[i] != i + 1) bad++;
        n_checks++; if (bad != 0) $display("FAIL clr_sequence: got %0d bad writes want 0", bad); else n_pass++;
        n_checks++; if (fb_diff() != 0) $display("FAIL clr_fb: got %0d words differ want 0", fb_diff()); else n_pass++;
        n_checks++; if (busy_bad != 0) $display("FAIL clr_busy: got %0d low cycles want 0", busy_bad); else n_pass++;
        repeat (3) @(negedge clk);
        n_checks++; if (busy !== 1'b0) $display("FAIL clr_restart: got busy %b want 0", busy); else n_pass++;
    endtask

    task automatic test_first_draw();
        int lat; bit tmo; bit c_exp; int l_exp; int w_exp;
        spr_mem[0] = 8'hF0;
        run_cmd(1'b0, 1'b1, 1'b0, 7'd0, 6'd0, 4'd1, 1'b0, lat, tmo);
        model_draw(1'b0, 0, 0, 1, c_exp, l_exp, w_exp);
        n_checks++; if (tmo || lat != 4) $display("FAIL t1_latency: got %0d want 4", lat); else n_pass++;
        n_checks++; if (wr_cyc.size() != 1 || wr_cyc[0] != 3) $display("FAIL t1_we_cycle: got %0d writes want 1 at T+3", wr_cyc.size()); else n_pass++;
        n_checks++; if (wr_addr.size() != 1 || wr_addr[0] !== 9'd0 || wr_data[0] !== 16'hF000) $display("FAIL t1_write: got %0d writes want addr 0 data F000", wr_addr.size()); else n_pass++;
        n_checks++; if (collision !== 1'b0) $display("FAIL t1_coll: got %b want 0", collision); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL t1_busy_at_done: got %b want 0", busy); else n_pass++;
        @(negedge clk);
        n_checks++; if (done !== 1'b0) $display("FAIL t1_done_pulse: got %b want 0", done); else n_pass++;
        n_checks++; if (fb_mem[0] !== 16'hF000) $display("FAIL t1_word0: got %h want F000", fb_mem[0]); else n_pass++;
        run_cmd(1'b0, 1'b1, 1'b0, 7'd0, 6'd0, 4'd1, 1'b0, lat, tmo);
        model_draw(1'b0, 0, 0, 1, c_exp, l_exp, w_exp);
        @(negedge clk);
        n_checks++; if (fb_mem[0] !== 16'h0000) $display("FAIL t2_word0: got %h want 0000", fb_mem[0]); else n_pass++;
        n_checks++; if (collision !== 1'b1) $display("FAIL t2_coll: got %b want 1", collision); else n_pass++;
        repeat (6) @(negedge clk);
        n_checks++; if (collision !== 1'b1) $display("FAIL t2_coll_hold: got %b want 1", collision); else n_pass++;
    endtask

    task automatic test_split();
        int lat; bit tmo; bit c_exp; int l_exp; int w_exp;
        spr_mem[0] = 8'hFF;
        run_cmd(1'b0, 1'b1, 1'b1, 7'd13, 6'd2, 4'd1, 1'b0, lat, tmo);
        model_draw(1'b1, 13, 2, 1, c_exp, l_exp, w_exp);
        n_checks++; if (tmo || lat != 6) $display("FAIL t3_latency: got %0d want 6", lat); else n_pass++;
        n_checks++; if (wr_addr.size() != 2 || wr_addr[0] !== 9'd16 || wr_data[0] !== 16'h0007 || wr_cyc[0] != 3)
            $display("FAIL t3_first_write: got %0d writes want addr 16 data 0007 at T+3", wr_addr.size()); else n_pass++;
        n_checks++; if (wr_addr.size() != 2 || wr_addr[1] !== 9'd17 || wr_data[1] !== 16'hF800 || wr_cyc[1] != 5)
            $display("FAIL t3_second_write: got %0d writes want addr 17 data F800 at T+5", wr_addr.size()); else n_pass++;
        n_checks++; if (collision !== 1'b0) $display("FAIL t3_coll: got %b want 0 (previous flag must clear)", collision); else n_pass++;
    endtask

    task automatic test_edge();
        int lat; bit tmo; bit c_exp; int l_exp; int w_exp;
        for (int i = 0; i < 3; i++) spr_mem[i] = 8'hFF;
        run_cmd(1'b0, 1'b1, 1'b0, 7'd60, 6'd30, 4'd3, 1'b0, lat, tmo);
        model_draw(1'b0, 60, 30, 3, c_exp, l_exp, w_exp);
        n_checks++; if (tmo || lat != l_exp) $display("FAIL t4_latency: got %0d want %0d", lat, l_exp); else n_pass++;
        n_checks++; if (fb_diff() != 0) $display("FAIL t4_fb: got %0d words differ want 0", fb_diff()); else n_pass++;
`ifdef SPRITE_WRAP_EN
        n_checks++; if (wr_addr.size() != 6 || wr_addr[0] !== 9'd123 || wr_addr[1] !== 9'd120 || wr_addr[4] !== 9'd3 || wr_addr[5] !== 9'd0)
            $display("FAIL t4_wrap_addrs: got %0d writes want 123,120,127,124,3,0", wr_addr.size()); else n_pass++;
`else
        n_checks++; if (wr_addr.size() != 2 || wr_addr[0] !== 9'd123 || wr_addr[1] !== 9'd127 || wr_data[0] !== 16'h000F || wr_data[1] !== 16'h000F)
            $display("FAIL t4_clip_writes: got %0d writes want 000F at 123 and 127", wr_addr.size()); else n_pass++;
        n_checks++; if (lat != 7) $display("FAIL t4_clip_latency: got %0d want 7", lat); else n_pass++;
`endif
    endtask

    task automatic test_reset_mid();
        int lat; bit tmo; bit c_exp; int l_exp; int w_exp; int wcount; bit hit;
        spr_mem[0] = 8'hFF;
        @(negedge clk);
        start = 1'b1; hires = 1'b1; x = 7'd13; y = 6'd2; n = 4'd1;
        @(negedge clk);
        start = 1'b0;
        wcount = 0; hit = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            if (fbWe) wcount++;
            if (wcount == 2) begin hit = 1'b1; break; end
            @(negedge clk);
        end
        n_checks++; if (!hit) $display("FAIL t6_reach_wr1: got %0d writes want 2", wcount); else n_pass++;
        n_checks++; if (collision !== 1'b1) $display("FAIL t6_coll_before: got %b want 1", collision); else n_pass++;
        reset = 1'b1;
        @(negedge clk);
        n_checks++; if (fbWe !== 1'b0) $display("FAIL t6_we: got %b want 0", fbWe); else n_pass++;
        n_checks++; if (busy !== 1'b0 || collision !== 1'b0) $display("FAIL t6_busy_coll: got %b%b want 00", busy, collision); else n_pass++;
        reset = 1'b0;
        model_draw(1'b1, 13, 2, 1, c_exp, l_exp, w_exp);
        spr_mem[0] = 8'hF0;
        run_cmd(1'b0, 1'b1, 1'b0, 7'd0, 6'd0, 4'd1, 1'b0, lat, tmo);
        model_draw(1'b0, 0, 0, 1, c_exp, l_exp, w_exp);
        n_checks++; if (tmo || lat != 4 || wr_cyc.size() != 1 || wr_cyc[0] != 3)
            $display("FAIL t6_redraw_timing: got latency %0d want 4", lat); else n_pass++;
        n_checks++; if (fb_diff() != 0) $display("FAIL t6_fb: got %0d words differ want 0", fb_diff()); else n_pass++;
        n_checks++; if (collision !== c_exp) $display("FAIL t6_redraw_coll: got %b want %b", collision, c_exp); else n_pass++;
    endtask

    task automatic test_random();
        int lat; bit tmo; bit c_exp; int l_exp; int w_exp;
        bit hi; int xi; int yi; int ni;
        for (int it = 0; it < 40; it++) begin
            hi = 1'($urandom); xi = $urandom_range(0, 127); yi = $urandom_range(0, 63); ni = $urandom_range(0, 15);
            for (int r = 0; r < 16; r++) spr_mem[r] = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
            run_cmd(1'b0, 1'b1, hi, 7'(xi), 6'(yi), 4'(ni), 1'b0, lat, tmo);
            model_draw(hi, xi, yi, ni, c_exp, l_exp, w_exp);
            n_checks++; if (tmo || lat != l_exp) $display("FAIL rnd%0d_latency: got %0d want %0d", it, lat, l_exp); else n_pass++;
            n_checks++; if (wr_addr.size() != w_exp) $display("FAIL rnd%0d_writes: got %0d want %0d", it, wr_addr.size(), w_exp); else n_pass++;
            n_checks++; if (collision !== c_exp) $display("FAIL rnd%0d_coll: got %b want %b", it, collision, c_exp); else n_pass++;
            n_checks++; if (busy !== 1'b0 || busy_bad != 0) $display("FAIL rnd%0d_busy: got %b/%0d want 0/0", it, busy, busy_bad); else n_pass++;
            @(negedge clk);
            n_checks++; if (fb_diff() != 0) $display("FAIL rnd%0d_fb: got %0d words differ want 0", it, fb_diff()); else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_clear_start();
        test_first_draw();
        test_split();
        test_edge();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
